// File: rtl/addr_map_cfg_pkg.sv
// Shared types for the address-map controller: rule layout, config field codes, FSM states.
// ADDR_MAP_CFG_OVERLAP_CHECK_EN adds the CHK_OVL state and uses rule_overlap().
package addr_map_cfg_pkg;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    int unsigned idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;

  localparam int unsigned RuleW = $bits(rule_t);

  typedef enum logic [1:0] {
    FIELD_IDX   = 2'd0,
    FIELD_START = 2'd1,
    FIELD_END   = 2'd2
  } cfg_field_e;

`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    CHK_OVL = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1
  } state_e;
`endif

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An end address of zero stands for the top of the address space (2^N).
  function automatic logic rule_overlap(input rule_t a, input rule_t b);
    logic [$bits(addr_t):0] w_end_a;
    logic [$bits(addr_t):0] w_end_b;
    w_end_a = (a.end_addr == '0) ? {1'b1, {$bits(addr_t){1'b0}}} : {1'b0, a.end_addr};
    w_end_b = (b.end_addr == '0) ? {1'b1, {$bits(addr_t){1'b0}}} : {1'b0, b.end_addr};
    return ({1'b0, b.start_addr} < w_end_a) && ({1'b0, a.start_addr} < w_end_b);
  endfunction

endpackage

// File: rtl/addr_rule_check.sv
// Combinational validity test of one rule: non-empty range (end==0 means top of space), legal idx.
// Zero latency; no flow control.
module addr_rule_check
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices = 32'd4
) (
  input  rule_t i_rule,
  output logic  o_ok
);

  logic w_range_ok;
  logic w_idx_ok;

  assign w_range_ok = (i_rule.start_addr < i_rule.end_addr) || (i_rule.end_addr == '0);
  assign w_idx_ok   = (i_rule.idx < NoIndices);
  assign o_ok       = w_range_ok && w_idx_ok;

endmodule

// File: rtl/addr_map_cfg.sv
// Shadow/active address map with commit-time validation, one rule (or pair) per cycle; config port stalls while busy.
// ADDR_MAP_CFG_OVERLAP_CHECK_EN adds a pairwise overlap pass before the atomic swap.
module addr_map_cfg
  import addr_map_cfg_pkg::*;
#(
  parameter  int unsigned NoIndices    = 32'd4,
  parameter  int unsigned NoRules      = 32'd4,
  localparam int unsigned RuleIdxWidth = idx_width(NoRules)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_req_i,
  output logic                       cfg_gnt_o,
  input  logic                       cfg_we_i,
  input  logic [RuleIdxWidth-1:0]    cfg_rule_i,
  input  logic [1:0]                 cfg_field_i,
  input  logic [$bits(addr_t)-1:0]   cfg_wdata_i,
  output logic [$bits(addr_t)-1:0]   cfg_rdata_o,
  output logic                       cfg_rvalid_o,
  input  logic                       commit_i,
  output logic                       busy_o,
  output logic                       commit_done_o,
  output logic                       commit_err_o,
  output logic [RuleIdxWidth-1:0]    err_rule_o,
  output logic                       map_valid_o,
  output logic [NoRules*RuleW-1:0]   addr_map_o
);

  state_e                  r_state, w_state_nxt;
  logic [RuleIdxWidth-1:0] r_cnt, w_cnt_nxt;
  rule_t [NoRules-1:0]     r_shadow;
  rule_t [NoRules-1:0]     r_active;
  logic [$bits(addr_t)-1:0] r_rdata;
  logic                    r_rvalid;
  logic                    r_done, w_done_nxt;
  logic                    r_err, w_err_nxt;
  logic [RuleIdxWidth-1:0] r_err_rule, w_err_rule_nxt;
  logic                    r_map_valid;
  logic                    w_swap;
  logic                    w_gnt;
  logic                    w_rule_legal;
  logic                    w_rule_ok;
  logic [$bits(addr_t)-1:0] w_rd_val;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
  logic [RuleIdxWidth-1:0] r_j, w_j_nxt;
`endif

  assign w_gnt        = cfg_req_i && (r_state == IDLE);
  assign w_rule_legal = (32'(cfg_rule_i) < NoRules) && (cfg_field_i != 2'd3);

  addr_rule_check #(
    .NoIndices (NoIndices)
  ) u_rule_check (
    .i_rule (r_shadow[r_cnt]),
    .o_ok   (w_rule_ok)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_rule_nxt = r_err_rule;
    w_swap         = 1'b0;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
    w_j_nxt        = r_j;
`endif
    unique case (r_state)
      IDLE: begin
        if (commit_i) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = '0;
        end
      end
      CHECK: begin
        if (!w_rule_ok) begin
          w_err_nxt      = 1'b1;
          w_err_rule_nxt = r_cnt;
          w_state_nxt    = IDLE;
        end else if (32'(r_cnt) == NoRules - 1) begin
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
          if (NoRules > 1) begin
            w_state_nxt = CHK_OVL;
            w_cnt_nxt   = '0;
            w_j_nxt     = RuleIdxWidth'(1);
          end else begin
            w_swap      = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
`else
          w_swap      = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt + RuleIdxWidth'(1);
        end
      end
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      // r_cnt is the lower rule i, r_j the upper rule j of the pair under test.
      CHK_OVL: begin
        if (rule_overlap(r_shadow[r_cnt], r_shadow[r_j])) begin
          w_err_nxt      = 1'b1;
          w_err_rule_nxt = r_j;
          w_state_nxt    = IDLE;
        end else if (32'(r_j) == NoRules - 1) begin
          if (32'(r_cnt) == NoRules - 2) begin
            w_swap      = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + RuleIdxWidth'(1);
            w_j_nxt   = r_cnt + RuleIdxWidth'(2);
          end
        end else begin
          w_j_nxt = r_j + RuleIdxWidth'(1);
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_rule  <= '0;
      r_map_valid <= 1'b0;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      r_j         <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_rule <= w_err_rule_nxt;
      if (w_swap) r_map_valid <= 1'b1;
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
      r_j        <= w_j_nxt;
`endif
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_rule_legal) begin
      case (cfg_field_e'(cfg_field_i))
        FIELD_IDX:   w_rd_val = r_shadow[cfg_rule_i].idx;
        FIELD_START: w_rd_val = r_shadow[cfg_rule_i].start_addr;
        FIELD_END:   w_rd_val = r_shadow[cfg_rule_i].end_addr;
        default:     w_rd_val = '0;
      endcase
    end
  end

  // Shadow writes land at the accepting edge, so a write paired with commit_i is checked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= '0;
      r_active <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_gnt && !cfg_we_i;
      if (w_gnt && !cfg_we_i) r_rdata <= w_rd_val;
      if (w_gnt && cfg_we_i && w_rule_legal) begin
        case (cfg_field_e'(cfg_field_i))
          FIELD_IDX:   r_shadow[cfg_rule_i].idx        <= cfg_wdata_i;
          FIELD_START: r_shadow[cfg_rule_i].start_addr <= cfg_wdata_i;
          FIELD_END:   r_shadow[cfg_rule_i].end_addr   <= cfg_wdata_i;
          default:     ;
        endcase
      end
      if (w_swap) r_active <= r_shadow;
    end
  end

  assign cfg_gnt_o     = w_gnt;
  assign cfg_rdata_o   = r_rdata;
  assign cfg_rvalid_o  = r_rvalid;
  assign busy_o        = (r_state != IDLE);
  assign commit_done_o = r_done;
  assign commit_err_o  = r_err;
  assign err_rule_o    = r_err_rule;
  assign map_valid_o   = r_map_valid;
  assign addr_map_o    = r_active;

endmodule

// File: tb/tb_addr_map_cfg.sv
// Directed bench for addr_map_cfg (NoRules=4, NoIndices=4); expectations follow ADDR_MAP_CFG_OVERLAP_CHECK_EN.
module tb_addr_map_cfg;
  import addr_map_cfg_pkg::*;

`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
  localparam int OK_EDGES = 11;
`else
  localparam int OK_EDGES = 5;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_req_i = 1'b0;
  logic          cfg_gnt_o;
  logic          cfg_we_i = 1'b0;
  logic [1:0]    cfg_rule_i = '0;
  logic [1:0]    cfg_field_i = '0;
  logic [31:0]   cfg_wdata_i = '0;
  logic [31:0]   cfg_rdata_o;
  logic          cfg_rvalid_o;
  logic          commit_i = 1'b0;
  logic          busy_o;
  logic          commit_done_o;
  logic          commit_err_o;
  logic [1:0]    err_rule_o;
  logic          map_valid_o;
  logic [4*RuleW-1:0] addr_map_o;

  addr_map_cfg #(.NoIndices(32'd4), .NoRules(32'd4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_we_i(cfg_we_i),
    .cfg_rule_i(cfg_rule_i), .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o), .cfg_rvalid_o(cfg_rvalid_o),
    .commit_i(commit_i), .busy_o(busy_o), .commit_done_o(commit_done_o),
    .commit_err_o(commit_err_o), .err_rule_o(err_rule_o),
    .map_valid_o(map_valid_o), .addr_map_o(addr_map_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  rule_t [3:0] sh = '0;
  rule_t [3:0] exp_act = '0;

  typedef struct {
    bit          we;
    logic [1:0]  rule;
    logic [1:0]  field;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_map(input string name);
    n_chk++;
    if (addr_map_o === exp_act) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, addr_map_o, exp_act);
  endtask

  task automatic cfg_write(input logic [1:0] rule, input logic [1:0] field, input logic [31:0] data);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1;
    cfg_rule_i = rule; cfg_field_i = field; cfg_wdata_i = data;
    @(posedge clk_i); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    case (field)
      2'd0: sh[rule].idx = data;
      2'd1: sh[rule].start_addr = data;
      2'd2: sh[rule].end_addr = data;
      default: ;
    endcase
  endtask

  task automatic cfg_read(input logic [1:0] rule, input logic [1:0] field,
                          output logic [31:0] data, output logic valid);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0;
    cfg_rule_i = rule; cfg_field_i = field;
    @(posedge clk_i); #1;
    cfg_req_i = 1'b0;
    data = cfg_rdata_o;
    valid = cfg_rvalid_o;
  endtask

  // Edge count includes the accepting edge as edge 1.
  task automatic do_commit(input string name, input bit exp_ok, input int exp_edges,
                           input logic [1:0] exp_rule);
    int  n;
    bit  seen;
    commit_i = 1'b1;
    @(posedge clk_i); #1;
    commit_i = 1'b0; cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    n = 1;
    seen = 1'b0;
    chk({name, " busy"}, 64'(busy_o), 64'd1);
    while (!seen && n < 40) begin
      @(posedge clk_i); #1;
      n++;
      if (commit_done_o || commit_err_o) seen = 1'b1;
    end
    chk({name, " done"}, 64'(commit_done_o), 64'(exp_ok));
    chk({name, " err"}, 64'(commit_err_o), 64'(!exp_ok));
    chk({name, " edges"}, 64'(n), 64'(exp_edges));
    chk({name, " idle"}, 64'(busy_o), 64'd0);
    if (!exp_ok) chk({name, " err_rule"}, 64'(err_rule_o), 64'(exp_rule));
    if (exp_ok) begin
      exp_act = sh;
      chk({name, " map_valid"}, 64'(map_valid_o), 64'd1);
    end
    chk_map({name, " map"});
    @(posedge clk_i); #1;
    chk({name, " pulse width"}, 64'(commit_done_o || commit_err_o), 64'd0);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [31:0] rd;
    logic        rv;
    int          gnt_bad;
    int          extra_done;
    int          n;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst map", 64'(addr_map_o == '0), 64'd1);
    chk("rst map_valid", 64'(map_valid_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst pulses", 64'({commit_done_o, commit_err_o, cfg_rvalid_o}), 64'd0);
    chk("rst err_rule", 64'(err_rule_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    cfg_req_i = 1'b1; #1;
    chk("gnt follows req hi", 64'(cfg_gnt_o), 64'd1);
    cfg_req_i = 1'b0; #1;
    chk("gnt follows req lo", 64'(cfg_gnt_o), 64'd0);
    @(posedge clk_i); #1;
    cfg_read(2'd0, 2'd1, rd, rv);
    chk("rst shadow read", 64'(rd), 64'd0);

    // Program the base map
    for (int k = 0; k < 4; k++) begin
      cfg_write(2'(k), 2'd0, 32'(k));
      cfg_write(2'(k), 2'd1, 32'h1000 * 32'(k + 1));
      cfg_write(2'(k), 2'd2, 32'h1000 * 32'(k + 2));
    end

    vecs[0]  = '{0, 2'd2, 2'd1, 32'h0,        32'h3000};
    vecs[1]  = '{0, 2'd0, 2'd0, 32'h0,        32'h0};
    vecs[2]  = '{0, 2'd3, 2'd0, 32'h0,        32'h3};
    vecs[3]  = '{0, 2'd1, 2'd2, 32'h0,        32'h3000};
    vecs[4]  = '{0, 2'd3, 2'd2, 32'h0,        32'h5000};
    vecs[5]  = '{0, 2'd2, 2'd3, 32'h0,        32'h0};
    vecs[6]  = '{1, 2'd0, 2'd3, 32'hDEAD,     32'h0};
    vecs[7]  = '{0, 2'd0, 2'd1, 32'h0,        32'h1000};
    vecs[8]  = '{1, 2'd1, 2'd0, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{0, 2'd1, 2'd0, 32'h0,        32'hFFFF_FFFF};
    vecs[10] = '{1, 2'd1, 2'd0, 32'h1,        32'h0};
    vecs[11] = '{0, 2'd1, 2'd0, 32'h0,        32'h1};

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].we) begin
        cfg_write(vecs[v].rule, vecs[v].field, vecs[v].wdata);
        chk($sformatf("vec%0d rvalid low", v), 64'(cfg_rvalid_o), 64'd0);
      end else begin
        cfg_read(vecs[v].rule, vecs[v].field, rd, rv);
        chk($sformatf("vec%0d rdata", v), 64'(rd), 64'(vecs[v].exp_rdata));
        chk($sformatf("vec%0d rvalid", v), 64'(rv), 64'd1);
      end
    end

    do_commit("commit base", 1'b1, OK_EDGES, 2'd0);

    // Empty range on rule 2
    cfg_write(2'd2, 2'd2, 32'h2000);
    do_commit("commit bad range", 1'b0, 4, 2'd2);
    cfg_write(2'd2, 2'd2, 32'h4000);

    // Illegal idx written in the same cycle as the commit request
    cfg_req_i = 1'b1; cfg_we_i = 1'b1;
    cfg_rule_i = 2'd1; cfg_field_i = 2'd0; cfg_wdata_i = 32'd4;
    sh[1].idx = 4;
    do_commit("commit bad idx", 1'b0, 3, 2'd1);
    cfg_write(2'd1, 2'd0, 32'd1);

    // end == 0 stands for the top of the address space
    cfg_write(2'd3, 2'd1, 32'hF000_0000);
    cfg_write(2'd3, 2'd2, 32'h0);
    do_commit("commit end0", 1'b1, OK_EDGES, 2'd0);

    // Config port stalls while busy; a second commit mid-check is dropped
    commit_i = 1'b1;
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_rule_i = 2'd0; cfg_field_i = 2'd1;
    gnt_bad = 0;
    n = 1;
    while (!commit_done_o && !commit_err_o && n < 40) begin
      if (busy_o && cfg_gnt_o) gnt_bad++;
      commit_i = (n == 2);
      @(posedge clk_i); #1;
      n++;
    end
    commit_i = 1'b0;
    chk("stall no gnt", 64'(gnt_bad), 64'd0);
    chk("stall done", 64'(commit_done_o), 64'd1);
    chk("stall edges", 64'(n), 64'(OK_EDGES));
    chk("gnt after idle", 64'(cfg_gnt_o), 64'd1);
    cfg_req_i = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk_i); #1;
      if (commit_done_o || commit_err_o) extra_done++;
    end
    chk("ignored second commit", 64'(extra_done), 64'd0);

    // Overlapping rules 1 and 2
    cfg_write(2'd0, 2'd1, 32'h0800);
    cfg_write(2'd0, 2'd2, 32'h1000);
    cfg_write(2'd1, 2'd1, 32'h1000);
    cfg_write(2'd1, 2'd2, 32'h3000);
    cfg_write(2'd2, 2'd1, 32'h2000);
    cfg_write(2'd2, 2'd2, 32'h4000);
`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
    do_commit("commit overlap", 1'b0, 9, 2'd2);
`else
    do_commit("commit overlap", 1'b1, OK_EDGES, 2'd0);
`endif

    // Reset in the middle of a check clears both maps
    commit_i = 1'b1;
    @(posedge clk_i); #1;
    commit_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst map", 64'(addr_map_o == '0), 64'd1);
    chk("midrst busy", 64'(busy_o), 64'd0);
    chk("midrst map_valid", 64'(map_valid_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    cfg_read(2'd2, 2'd1, rd, rv);
    chk("midrst shadow", 64'(rd), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addr_map_cfg.md
Name: addr_map_cfg

Overview:
Run-time programmable address-map controller that drives the `addr_map_i` rule array of an `addr_decode` instance.
- Software writes rule fields into a shadow map through a req/gnt config port.
- A commit request starts a sequential validation FSM, one rule per cycle.
- The active map is replaced atomically only if every rule is valid, so the decoder never sees a half-written or illegal map.
- Sits between the peripheral config bus and the crossbar/demux address decoders.

Parameters:
- NoIndices, 32'd4, number of decoder output indices; a rule's idx must be < NoIndices.
- NoRules, 32'd4, number of rules in the map.
- addr_t, logic [31:0], address type.
- rule_t, packed struct {int unsigned idx; addr_t start_addr; addr_t end_addr}, rule type.
- RuleIdxWidth, cf_math_pkg::idx_width(NoRules), dependent, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- cfg_req_i  in  1  config access request.
- cfg_gnt_o  out  1  access accepted this cycle.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_rule_i  in  RuleIdxWidth  rule number.
- cfg_field_i  in  2  0 = idx, 1 = start_addr, 2 = end_addr, 3 = reserved.
- cfg_wdata_i  in  $bits(addr_t)  write data.
- cfg_rdata_o  out  $bits(addr_t)  read data.
- cfg_rvalid_o  out  1  read data valid.
- commit_i  in  1  request validation and swap.
- busy_o  out  1  FSM not IDLE.
- commit_done_o  out  1  one-cycle pulse: new map active.
- commit_err_o  out  1  one-cycle pulse: commit rejected.
- err_rule_o  out  RuleIdxWidth  rule that failed the last rejected commit.
- map_valid_o  out  1  at least one successful commit since reset.
- addr_map_o  out  NoRules*$bits(rule_t)  active map, feeds addr_decode.

Behaviour:
- Reset values:
  - shadow map, active map, cfg_rdata_o, err_rule_o: all zero.
  - cfg_rvalid_o, commit_done_o, commit_err_o, busy_o, map_valid_o: 0.
  - FSM in IDLE.
  - Reset mid-CHECK aborts the check and clears both maps.
- FSM states: IDLE, CHECK (plus CHK_OVL when the optional feature is enabled).
- cfg_gnt_o = cfg_req_i && state == IDLE. Requests are stalled (no grant) while busy.
- Config write: on a granted write, the selected shadow field is updated at the clock edge.
  - idx field: zero-extended or truncated from cfg_wdata_i to 32 bits.
  - cfg_rule_i >= NoRules or field 3: write dropped, still granted.
- Config read: a granted read returns the shadow field in cfg_rdata_o with cfg_rvalid_o high on the next cycle.
  - Illegal rule number or field returns 0.
- Commit acceptance: commit_i is sampled only in IDLE; it is ignored in all other states (no queueing).
  - If commit_i and a granted write occur in the same cycle, the write is included in the check.
- CHECK: counter i runs 0..NoRules-1, one rule per cycle. Rule i passes iff both hold:
  - (start_addr < end_addr) || (end_addr == 0);
  - idx < NoIndices.
- On the first failing rule:
  - commit_err_o pulses and err_rule_o <= i at the next edge;
  - FSM returns to IDLE;
  - active map is unchanged.
- If rule NoRules-1 passes:
  - active map <= shadow at that edge;
  - commit_done_o pulses and map_valid_o <= 1 in the same cycle the new addr_map_o is visible;
  - FSM returns to IDLE.
- Latency: a successful commit is visible NoRules+1 edges after the accepting edge. A failure at rule k is reported k+2 edges after it.
- commit_done_o and commit_err_o are never both high.
- addr_map_o changes only on a successful commit or on reset.

Optional Feature:
- Macro: ADDR_MAP_CFG_OVERLAP_CHECK_EN.
- When defined: after CHECK passes, FSM enters CHK_OVL and tests each pair (i<j) in lexicographic order, one pair per cycle, NoRules*(NoRules-1)/2 cycles.
  - Ranges overlap iff start_j < end_i' && start_i < end_j'. Here end_x' is end_x, or 2^$bits(addr_t) when end_x == 0.
  - Any overlap: commit_err_o pulses, err_rule_o = j, map unchanged.
  - Success latency becomes NoRules + NoRules*(NoRules-1)/2 + 1 edges.
- When undefined: overlapping rules are accepted; the decoder's higher-rule-wins priority applies.

Decomposition:
- addr_map_cfg_pkg holds:
  - cfg_field_e enum (FIELD_IDX, FIELD_START, FIELD_END);
  - state_e enum;
  - function rule_overlap().
- One sub-module, addr_rule_check: combinational single-rule validity check (rule, NoIndices → ok). Instantiated once, driven by the muxed rule[i].

Test Plan (NoRules=4, NoIndices=4, 32-bit addresses):
- Reset released → addr_map_o all zero, map_valid_o=0, cfg_gnt_o follows cfg_req_i.
- Program rules k=0..3 as idx=k, start=0x1000*(k+1), end=0x1000*(k+2). Read back rule 2 start → 0x3000 one cycle after grant. Commit → commit_done_o exactly 5 edges after acceptance, addr_map_o equals the shadow map, map_valid_o=1.
- Rule 2 start=0x3000, end=0x2000, then commit → commit_err_o pulse 4 edges after acceptance, err_rule_o=2, addr_map_o still holds the previous map.
- Rule 1 idx=4 → error with err_rule_o=1. Rule 3 end=0 with start=0xF000_0000 → passes.
- During CHECK: cfg_req_i held → cfg_gnt_o=0 until IDLE, then granted. Second commit_i pulse mid-CHECK → ignored (only one done pulse).
- Rule 1 = 0x1000–0x3000, rule 2 = 0x2000–0x4000. Macro defined → commit_err_o with err_rule_o=2. Macro undefined → commit_done_o.
